// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared constants and latency classes for the hazard scoreboard
// Contents:
//   MAX_LAT_DEF   default maximum producer latency
//   FWD_REGFILE   operand comes from the register file
//   FWD_BYPASS    operand comes from the completion bus
//   lat_e         nominal latency of each functional-unit class
package hazard_pkg;

    localparam int MAX_LAT_DEF = 8;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_BYPASS  = 2'b01;

    typedef enum logic [3:0] {
        LAT_ALU  = 4'd1,
        LAT_LOAD = 4'd2,
        LAT_MUL  = 4'd3,
        LAT_DIV  = 4'(MAX_LAT_DEF)
    } lat_e;

endpackage

// File: rtl/hazard_scoreboard_unit_wb_slot.sv
// rtl/hazard_scoreboard_unit_wb_slot.sv - writeback-port reservation shift register
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   clear_i           drop every reservation (next state all zero)
//   reserve_i         claim the slot reserve_lat_i cycles after issue
//   reserve_lat_i     latency of the claiming producer
//   query_lat_i       latency of the candidate producer
//   query_o           that slot is already claimed
//   empty_o           no reservation is outstanding
module wb_slot_reserve
    import hazard_pkg::*;
#(
    parameter int MAX_LAT = MAX_LAT_DEF,
    parameter int CW      = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_i,
    input  logic          reserve_i,
    input  logic [CW-1:0] reserve_lat_i,
    input  logic [CW-1:0] query_lat_i,
    output logic          query_o,
    output logic          empty_o
);

    // Bit k-1 stands for the writeback slot k cycles ahead.
    logic [MAX_LAT-1:0] slot_q;
    logic [MAX_LAT-1:0] slot_d;
    logic [MAX_LAT-1:0] slot_shift;

    // Reservations and queries are both made in the post-shift frame, so
    // a producer issued now collides with any earlier producer that will
    // occupy the same completion cycle.
    always_comb begin
        slot_shift = slot_q >> 1;
        slot_d     = slot_shift;
        query_o    = 1'b0;
        for (int k = 1; k <= MAX_LAT; k++) begin
            if (query_lat_i == CW'(k)) begin
                query_o = slot_shift[k-1];
            end
            if (reserve_i && (reserve_lat_i == CW'(k))) begin
                slot_d[k-1] = 1'b1;
            end
        end
        if (clear_i) begin
            slot_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign empty_o = ~|slot_q;

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// rtl/hazard_scoreboard_unit.sv - ID-stage scoreboard for variable-latency producers
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   issue_valid_ID                  ID instruction wants to issue
//   reg_write_ID, rd_ID, lat_ID     destination write, register, producer latency
//   rs1_ID/rs2_ID, rs1use_ID/rs2use_ID   source registers and their use flags
//   Branch_ID                       taken branch/jump resolved in ID
//   flush_all                       trap/exception squash
//   PC_EN_IF, reg_FD_EN             front-end enables (low while stalled)
//   reg_FD_flush, reg_DE_flush      IF/ID flush, ID/EX bubble
//   forward_ctrl_A/B                operand source select
//   sb_empty                        nothing in flight (fence condition)
module hazard_scoreboard_unit
    import hazard_pkg::*;
#(
    parameter int NREG    = 32,
    parameter int AW      = 5,
    parameter int MAX_LAT = MAX_LAT_DEF,
    parameter int CW      = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          issue_valid_ID,
    input  logic          reg_write_ID,
    input  logic [AW-1:0] rd_ID,
    input  logic [CW-1:0] lat_ID,
    input  logic [AW-1:0] rs1_ID,
    input  logic [AW-1:0] rs2_ID,
    input  logic          rs1use_ID,
    input  logic          rs2use_ID,
    input  logic          Branch_ID,
    input  logic          flush_all,
    output logic          PC_EN_IF,
    output logic          reg_FD_EN,
    output logic          reg_FD_flush,
    output logic          reg_DE_flush,
    output logic [1:0]    forward_ctrl_A,
    output logic [1:0]    forward_ctrl_B,
    output logic          sb_empty
);

    // Entry 0 exists only so source/destination indices can be used
    // directly; it is held at zero and never becomes pending.
    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;
    logic [CW-1:0]   cnt_q [NREG];
    logic [CW-1:0]   cnt_d [NREG];

    logic raw_a;
    logic raw_b;
    logic waw_stall;
    logic slot_busy;
    logic slot_stall;
    logic slot_empty;
    logic stall;
    logic issue;
    logic do_write;

    // A source whose producer has one cycle left is taken from the
    // completion bus; anything further out has to wait.
    always_comb begin
        raw_a          = 1'b0;
        forward_ctrl_A = FWD_REGFILE;
        if (rs1use_ID && (rs1_ID != '0) && pending_q[rs1_ID]) begin
            if (cnt_q[rs1_ID] == CW'(1)) begin
                forward_ctrl_A = FWD_BYPASS;
            end else begin
                raw_a = 1'b1;
            end
        end
    end

    always_comb begin
        raw_b          = 1'b0;
        forward_ctrl_B = FWD_REGFILE;
        if (rs2use_ID && (rs2_ID != '0) && pending_q[rs2_ID]) begin
            if (cnt_q[rs2_ID] == CW'(1)) begin
                forward_ctrl_B = FWD_BYPASS;
            end else begin
                raw_b = 1'b1;
            end
        end
    end

    // A younger write may not land before an older write to the same rd.
    assign waw_stall = reg_write_ID && (rd_ID != '0) && pending_q[rd_ID]
                       && (cnt_q[rd_ID] > lat_ID);

    assign slot_stall = reg_write_ID & slot_busy;

    assign stall    = issue_valid_ID & (raw_a | raw_b | waw_stall | slot_stall) & ~flush_all;
    assign issue    = issue_valid_ID & ~stall & ~flush_all;
    assign do_write = issue & reg_write_ID & (rd_ID != '0);

    assign PC_EN_IF     = ~stall;
    assign reg_FD_EN    = ~stall;
    assign reg_DE_flush = stall | flush_all;
    // A branch held in ID by a stall is acted on only once it leaves.
    assign reg_FD_flush = (Branch_ID & ~stall) | flush_all;

    wb_slot_reserve #(
        .MAX_LAT (MAX_LAT),
        .CW      (CW)
    ) u_wb_slot (
        .clk           (clk),
        .rst_n         (rst_n),
        .clear_i       (flush_all),
        .reserve_i     (do_write),
        .reserve_lat_i (lat_ID),
        .query_lat_i   (lat_ID),
        .query_o       (slot_busy),
        .empty_o       (slot_empty)
    );

    // Counters run down every cycle regardless of stall; a fresh issue to
    // the same rd overrides the old entry, even one finishing this cycle.
    always_comb begin
        pending_d = pending_q;
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
        end
        for (int r = 1; r < NREG; r++) begin
            if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - CW'(1);
            end
            if (cnt_q[r] == CW'(1)) begin
                pending_d[r] = 1'b0;
            end
            if (do_write && (rd_ID == AW'(r))) begin
                pending_d[r] = 1'b1;
                cnt_d[r]     = lat_ID;
            end
        end
        pending_d[0] = 1'b0;
        cnt_d[0]     = '0;
        if (flush_all) begin
            pending_d = '0;
            for (int r = 0; r < NREG; r++) begin
                cnt_d[r] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            pending_q <= pending_d;
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    assign sb_empty = ~|pending_q & slot_empty;

    lat_legal_a : assert property (@(posedge clk) disable iff (!rst_n)
        (issue_valid_ID && reg_write_ID) |-> ((lat_ID != '0) && (lat_ID <= CW'(MAX_LAT))))
        else $error("illegal producer latency %0d", lat_ID);

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb/tb_hazard_scoreboard_unit.sv - self-checking bench for hazard_scoreboard_unit
module tb_hazard_scoreboard_unit;
    import hazard_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       issue_valid_ID, reg_write_ID, rs1use_ID, rs2use_ID, Branch_ID, flush_all;
    logic [4:0] rd_ID, rs1_ID, rs2_ID;
    logic [3:0] lat_ID;
    logic       PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush, sb_empty;
    logic [1:0] forward_ctrl_A, forward_ctrl_B;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .issue_valid_ID (issue_valid_ID),
        .reg_write_ID   (reg_write_ID),
        .rd_ID          (rd_ID),
        .lat_ID         (lat_ID),
        .rs1_ID         (rs1_ID),
        .rs2_ID         (rs2_ID),
        .rs1use_ID      (rs1use_ID),
        .rs2use_ID      (rs2use_ID),
        .Branch_ID      (Branch_ID),
        .flush_all      (flush_all),
        .PC_EN_IF       (PC_EN_IF),
        .reg_FD_EN      (reg_FD_EN),
        .reg_FD_flush   (reg_FD_flush),
        .reg_DE_flush   (reg_DE_flush),
        .forward_ctrl_A (forward_ctrl_A),
        .forward_ctrl_B (forward_ctrl_B),
        .sb_empty       (sb_empty)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: each register remembers the cycle its result is on
    // the completion bus; the writeback port is a set of claimed cycles.
    int cyc_n = 0;
    int done_at [32];
    bit resv [int];

    function automatic int src_state(input int r, input bit used);
        if (!used || r == 0 || done_at[r] < cyc_n) return 0;
        if (done_at[r] == cyc_n) return 1;
        return 2;
    endfunction

    always @(negedge clk) begin
        int  sa, sb, rd, lat;
        bit  raw, waw, slot, stl, iss, empty;
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) done_at[r] = -1;
            resv.delete();
        end
        rd   = int'(rd_ID);
        lat  = int'(lat_ID);
        sa   = src_state(int'(rs1_ID), rs1use_ID);
        sb   = src_state(int'(rs2_ID), rs2use_ID);
        raw  = (sa == 2) || (sb == 2);
        waw  = reg_write_ID && rd != 0 && done_at[rd] >= cyc_n && (done_at[rd] - cyc_n + 1 > lat);
        slot = reg_write_ID && resv.exists(cyc_n + lat);
        stl  = issue_valid_ID && (raw || waw || slot) && !flush_all;
        iss  = issue_valid_ID && !stl && !flush_all;
        empty = 1'b1;
        for (int r = 1; r < 32; r++) if (done_at[r] >= cyc_n) empty = 1'b0;
        foreach (resv[k]) if (k >= cyc_n) empty = 1'b0;

        check("PC_EN_IF", PC_EN_IF, !stl);
        check("reg_FD_EN", reg_FD_EN, !stl);
        check("reg_DE_flush", reg_DE_flush, stl || flush_all);
        check("reg_FD_flush", reg_FD_flush, (Branch_ID && !stl) || flush_all);
        check("forward_ctrl_A", forward_ctrl_A, (sa == 1) ? 1 : 0);
        check("forward_ctrl_B", forward_ctrl_B, (sb == 1) ? 1 : 0);
        check("sb_empty", sb_empty, empty);

        if (rst_n) begin
            if (flush_all) begin
                for (int r = 0; r < 32; r++) done_at[r] = -1;
                resv.delete();
            end else if (iss && reg_write_ID && rd != 0) begin
                done_at[rd] = cyc_n + lat;
                resv[cyc_n + lat] = 1'b1;
            end
        end
        cyc_n++;
    end

    task automatic cyc(input int v, input int wr, input int rd, input int lat,
                       input int r1, input int u1, input int r2, input int u2,
                       input int br, input int fl);
        @(posedge clk);
        #1;
        issue_valid_ID = v[0];
        reg_write_ID   = wr[0];
        rd_ID          = rd[4:0];
        lat_ID         = lat[3:0];
        rs1_ID         = r1[4:0];
        rs1use_ID      = u1[0];
        rs2_ID         = r2[4:0];
        rs2use_ID      = u2[0];
        Branch_ID      = br[0];
        flush_all      = fl[0];
        #3;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int stalls;
        bit done;
        rst_n = 1'b0;
        issue_valid_ID = 0; reg_write_ID = 0; rd_ID = 0; lat_ID = 1;
        rs1_ID = 0; rs2_ID = 0; rs1use_ID = 0; rs2use_ID = 0; Branch_ID = 0; flush_all = 0;
        idle(3);
        check("reset_sb_empty", sb_empty, 1);
        check("reset_pc_en", PC_EN_IF, 1);
        @(posedge clk); #1 rst_n = 1'b1;

        // load-use: one bubble, then bypass
        cyc(1, 1, 5, int'(LAT_LOAD), 0, 0, 0, 0, 0, 0);
        check("raw_prod_no_stall", reg_DE_flush, 0);
        cyc(1, 0, 0, 1, 5, 1, 0, 0, 0, 0);
        check("raw_load_stall", reg_DE_flush, 1);
        check("raw_load_pc_hold", PC_EN_IF, 0);
        cyc(1, 0, 0, 1, 5, 1, 0, 0, 0, 0);
        check("raw_load_go", reg_DE_flush, 0);
        check("raw_load_fwd", forward_ctrl_A, 1);
        idle(2);

        // divide consumer: seven bubbles, bypass on the eighth cycle
        cyc(1, 1, 7, int'(LAT_DIV), 0, 0, 0, 0, 0, 0);
        stalls = 0; done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            cyc(1, 0, 0, 1, 0, 0, 7, 1, 0, 0);
            if (reg_DE_flush) stalls++;
            else begin
                done = 1;
                check("div_fwd_b", forward_ctrl_B, 1);
            end
        end
        check("div_stalls", stalls, 7);
        check("div_done", done, 1);
        cyc(1, 1, 7, int'(LAT_DIV), 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 9, 1, 7, 0, 0, 0);
        check("indep_no_stall", reg_DE_flush, 0);
        check("indep_fwd_b_unused", forward_ctrl_B, 0);
        idle(9);

        // WAW: short write to x3 waits for the long one to be one cycle out
        cyc(1, 1, 3, 8, 0, 0, 0, 0, 0, 0);
        stalls = 0; done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            cyc(1, 1, 3, 1, 0, 0, 0, 0, 0, 0);
            if (reg_DE_flush) stalls++;
            else done = 1;
        end
        check("waw_stalls", stalls, 7);
        idle(3);

        // writeback-port collision
        cyc(1, 1, 4, int'(LAT_MUL), 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 6, 2, 0, 0, 0, 0, 0, 0);
        check("slot_stall", reg_DE_flush, 1);
        cyc(1, 1, 6, 2, 0, 0, 0, 0, 0, 0);
        check("slot_go", reg_DE_flush, 0);
        idle(4);

        // branch held by a stall
        cyc(1, 1, 5, 2, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 5, 1, 0, 0, 1, 0);
        check("br_stalled_fd_flush", reg_FD_flush, 0);
        check("br_stalled_de_flush", reg_DE_flush, 1);
        cyc(1, 0, 0, 1, 5, 1, 0, 0, 1, 0);
        check("br_go_fd_flush", reg_FD_flush, 1);
        idle(4);

        // flush_all with several in flight
        cyc(1, 1, 1, 8, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 2, 4, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 3, 2, 0, 0, 0, 0, 0, 0);
        check("pre_flush_busy", sb_empty, 0);
        cyc(1, 1, 9, 1, 0, 0, 0, 0, 0, 1);
        check("flush_de", reg_DE_flush, 1);
        check("flush_fd", reg_FD_flush, 1);
        cyc(1, 0, 0, 1, 1, 1, 0, 0, 0, 0);
        check("post_flush_empty", sb_empty, 1);
        check("post_flush_no_stall", reg_DE_flush, 0);
        check("post_flush_fwd", forward_ctrl_A, 0);

        // asynchronous reset in the middle of a cycle
        cyc(1, 1, 1, 8, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 1, 1, 0, 0, 0, 0);
        check("pre_reset_stall", reg_DE_flush, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_sb_empty", sb_empty, 1);
        check("async_pc_en", PC_EN_IF, 1);
        check("async_de_flush", reg_DE_flush, 0);
        check("async_fd_flush", reg_FD_flush, 0);
        check("async_fwd_a", forward_ctrl_A, 0);
        idle(2);
        @(posedge clk); #1 rst_n = 1'b1;

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 3) != 0) ? 1 : 0,
                ($urandom_range(0, 3) != 0) ? 1 : 0,
                int'($urandom_range(0, 7)),
                int'($urandom_range(1, 8)),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                ($urandom_range(0, 7) == 0) ? 1 : 0,
                ($urandom_range(0, 23) == 0) ? 1 : 0);
        end
        idle(10);
        check("drained_empty", sb_empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
